triangle_feeder: RTL and testbench
==================================

TRIANGLE_FEEDER -- requirements
Module: triangle_feeder

Interface
REQ-001 Parameters, one per line:
  ADDR_W, 16, vertex-memory address width.
  MODEL_W, 8, model-table address width and model-count width.
REQ-002 Ports, one per line (name, direction, width, meaning); there is one clock, and reset is asynchronous and active-high:
  clk  in  1  sole clock.
  rst  in  1  asynchronous active-high reset.
  start  in  1  single-cycle frame start request.
  num_models  in  MODEL_W  number of model instances this frame, sampled at start.
  camera_transform  in  transform_t  camera transform, sampled at start.
  model_addr  out  MODEL_W  model-table read address.
  model_rd_en  out  1  model-table read strobe; data arrives 1 cycle later.
  model_transform  in  transform_t  model-table read data: transform.
  model_tri_base  in  ADDR_W  model-table read data: first vertex address.
  model_tri_count  in  ADDR_W  model-table read data: triangle count.
  vert_addr  out  ADDR_W  vertex-memory read address.
  vert_rd_en  out  1  vertex-memory read strobe; data arrives 1 cycle later.
  vert_data  in  vertex_t  vertex-memory read data.
  camera_transform_valid  out  1  1-cycle pulse loading the downstream camera matrix.
  transform  out  transform_t  transform presented downstream.
  triangle  out  triangle_t  triangle presented downstream.
  out_valid  out  1  triangle and transform are valid.
  out_ready  in  1  downstream accepts the triangle.
  down_busy  in  1  downstream pipeline is non-empty.
  busy  out  1  high in any state other than IDLE.
  done  out  1  1-cycle pulse after the last triangle of the frame is accepted.

Function
REQ-003 States: IDLE, CAM_WAIT, CAM, MODEL_RD, MODEL_LAT, VTX_FETCH, EMIT, DONE.
REQ-004 In IDLE, start SHALL latch num_models and camera_transform and move to CAM_WAIT. start SHALL be ignored in every other state.
REQ-005 CAM_WAIT SHALL hold until down_busy=0 and then move to CAM.
REQ-006 In CAM, camera_transform_valid SHALL be 1 for exactly one cycle, with transform = latched camera_transform and out_valid = 0.
REQ-007 After CAM, the next state SHALL be DONE if num_models = 0, otherwise MODEL_RD with model index m = 0.
REQ-008 MODEL_RD SHALL assert model_rd_en for 1 cycle with model_addr = m.
REQ-009 In MODEL_LAT, the block SHALL latch model_transform, model_tri_base and model_tri_count, and set the triangle index t = 0.
REQ-010 If the latched model_tri_count = 0, the model SHALL be skipped with no output; otherwise the next state is VTX_FETCH.
REQ-011 VTX_FETCH SHALL issue three consecutive reads with vert_rd_en = 1 at addresses base + 3t + k, k = 0..2, computed modulo 2^ADDR_W.
REQ-012 The read data for vertex k SHALL be captured into triangle.vk one cycle after its read. EMIT SHALL be entered 4 cycles after the first read.
REQ-013 In EMIT, out_valid SHALL be 1, and triangle and transform (the model transform) SHALL stay stable until out_ready=1.
REQ-014 A transfer SHALL occur on any cycle with out_valid=1 and out_ready=1. out_valid SHALL drop in the following cycle unless the next triangle is already ready.
REQ-015 After a transfer: if t+1 < count, then t increments and the state returns to VTX_FETCH. Otherwise, if m+1 < num_models, m increments and the state returns to MODEL_RD. Otherwise the state goes to DONE.
REQ-016 DONE SHALL pulse done for 1 cycle and return to IDLE.
REQ-017 out_valid SHALL never assert before the camera pulse of the same frame, and the two SHALL never be high together.
REQ-018 Steady-state throughput SHALL be 1 triangle per 5 cycles when out_ready is held at 1.

Reset
REQ-019 rst SHALL return the state machine to IDLE immediately, including mid-frame. Any pending triangle is discarded.
REQ-020 Reset values: every output 0, all counters 0, all latched transforms 0.
REQ-021 rst release SHALL be synchronised internally so that the first state transition occurs on a clean clk edge.

Structure
REQ-022 The feeder_state_t enum and the ADDR_W/MODEL_W defaults SHALL be placed in transformer_pkg. transform_t and triangle_t come from existing packages.
REQ-023 There SHALL be no sub-module; this is a single FSM plus address datapath.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
  num_models=0, start -> camera pulse, then done 2 cycles later, and out_valid never asserted.
  1 model, base=0, count=2, out_ready=1 -> vert_addr sequence 0,1,2,3,4,5; 2 triangles accepted; done pulses once.
  out_ready held 0 for 10 cycles in EMIT -> triangle and transform stable, out_valid=1 throughout.
  down_busy=1 for 7 cycles after start -> camera_transform_valid delayed until the first cycle with down_busy=0.
  base=0xFFFE, count=1 -> addresses 0xFFFE, 0xFFFF, 0x0000.
  rst asserted mid VTX_FETCH -> all outputs 0 asynchronously; the next start begins a clean frame.

Source files
------------

// File: rtl/transformer_pkg.sv
// Shared types and defaults for the transform stage: geometry records and
// the triangle feeder state encoding.
package transformer_pkg;

  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned MODEL_W_DEF = 8;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } vertex_t;

  typedef struct packed {
    logic [15:0] rot;
    logic [15:0] tx;
    logic [15:0] ty;
    logic [15:0] tz;
  } transform_t;

  typedef struct packed {
    vertex_t v0;
    vertex_t v1;
    vertex_t v2;
  } triangle_t;

  typedef enum logic [2:0] {
    IDLE,
    CAM_WAIT,
    CAM,
    MODEL_RD,
    MODEL_LAT,
    VTX_FETCH,
    EMIT,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/triangle_feeder.sv
// Walks the model table for one frame and streams every triangle of every
// model downstream, preceded by a single camera-transform load pulse.
module triangle_feeder
  import transformer_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned MODEL_W = MODEL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MODEL_W-1:0] num_models,
  input  transform_t         camera_transform,
  output logic [MODEL_W-1:0] model_addr,
  output logic               model_rd_en,
  input  transform_t         model_transform,
  input  logic [ADDR_W-1:0]  model_tri_base,
  input  logic [ADDR_W-1:0]  model_tri_count,
  output logic [ADDR_W-1:0]  vert_addr,
  output logic               vert_rd_en,
  input  vertex_t            vert_data,
  output logic               camera_transform_valid,
  output transform_t         transform,
  output triangle_t          triangle,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               down_busy,
  output logic               busy,
  output logic               done
);

  feeder_state_t      state_q, state_d;
  logic [1:0]         rst_pipe;
  logic               rst_hold;
  logic [MODEL_W-1:0] num_q, m_q;
  transform_t         cam_q, xf_q;
  logic [ADDR_W-1:0]  cnt_q, t_q, addr_q;
  logic [1:0]         k_q;
  triangle_t          tri_q;
  logic               done_q;
  logic               more_models, more_tris;

  // Reset asserts immediately but releases only after two clean edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_pipe <= 2'b11;
    else     rst_pipe <= {rst_pipe[0], 1'b0};
  end
  assign rst_hold = rst_pipe[1];

  assign more_models = ({1'b0, m_q} + (MODEL_W+1)'(1)) < {1'b0, num_q};
  assign more_tris   = (t_q + ADDR_W'(1)) < cnt_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start) state_d = CAM_WAIT;
      CAM_WAIT:  if (!down_busy) state_d = CAM;
      CAM:       state_d = (num_q == '0) ? DONE : MODEL_RD;
      MODEL_RD:  state_d = MODEL_LAT;
      // Decide on the live read data; it is the same value being latched.
      MODEL_LAT: begin
        if (model_tri_count != '0) state_d = VTX_FETCH;
        else if (more_models)      state_d = MODEL_RD;
        else                       state_d = DONE;
      end
      VTX_FETCH: if (k_q == 2'd3) state_d = EMIT;
      EMIT: begin
        if (out_ready) begin
          if (more_tris)        state_d = VTX_FETCH;
          else if (more_models) state_d = MODEL_RD;
          else                  state_d = DONE;
        end
      end
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      num_q   <= '0;
      m_q     <= '0;
      cam_q   <= '0;
      xf_q    <= '0;
      cnt_q   <= '0;
      t_q     <= '0;
      addr_q  <= '0;
      k_q     <= '0;
      tri_q   <= '0;
      done_q  <= 1'b0;
    end else if (rst_hold) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == DONE);
      unique case (state_q)
        IDLE: if (start) begin
          num_q <= num_models;
          cam_q <= camera_transform;
        end
        CAM: m_q <= '0;
        MODEL_LAT: begin
          xf_q   <= model_transform;
          cnt_q  <= model_tri_count;
          addr_q <= model_tri_base;
          t_q    <= '0;
          k_q    <= '0;
          if (model_tri_count == '0 && more_models) m_q <= m_q + MODEL_W'(1);
        end
        // Reads go out while k = 0..2; each datum is captured one step later.
        VTX_FETCH: begin
          k_q <= k_q + 2'd1;
          if (k_q != 2'd3) addr_q <= addr_q + ADDR_W'(1);
          if (k_q == 2'd1) tri_q.v0 <= vert_data;
          if (k_q == 2'd2) tri_q.v1 <= vert_data;
          if (k_q == 2'd3) tri_q.v2 <= vert_data;
        end
        EMIT: if (out_ready) begin
          if (more_tris)        t_q <= t_q + ADDR_W'(1);
          else if (more_models) m_q <= m_q + MODEL_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy                   = (state_q != IDLE);
  assign camera_transform_valid = (state_q == CAM);
  assign model_rd_en            = (state_q == MODEL_RD);
  assign model_addr             = m_q;
  assign vert_rd_en             = (state_q == VTX_FETCH) && (k_q != 2'd3);
  assign vert_addr              = addr_q;
  assign out_valid              = (state_q == EMIT);
  assign triangle               = tri_q;
  assign done                   = done_q;

  always_comb begin
    transform = '0;
    if (state_q == CAM)       transform = cam_q;
    else if (state_q == EMIT) transform = xf_q;
  end

endmodule

// File: tb/tb_triangle_feeder.sv
// Scoreboard bench for triangle_feeder: a frame-level reference model queues
// the expected camera load, reads and triangles; a monitor checks them.
module tb_triangle_feeder;
  import transformer_pkg::*;

  localparam int unsigned AW = 16;
  localparam int unsigned MW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [MW-1:0] num_models;
  transform_t    camera_transform;
  logic [MW-1:0] model_addr;
  logic          model_rd_en;
  transform_t    model_transform;
  logic [AW-1:0] model_tri_base;
  logic [AW-1:0] model_tri_count;
  logic [AW-1:0] vert_addr;
  logic          vert_rd_en;
  vertex_t       vert_data;
  logic          camera_transform_valid;
  transform_t    transform;
  triangle_t     triangle;
  logic          out_valid;
  logic          out_ready;
  logic          down_busy;
  logic          busy;
  logic          done;

  typedef struct packed {
    triangle_t  tri_v;
    transform_t xf;
  } exp_t;

  triangle_feeder #(.ADDR_W(AW), .MODEL_W(MW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_models(num_models),
    .camera_transform(camera_transform), .model_addr(model_addr),
    .model_rd_en(model_rd_en), .model_transform(model_transform),
    .model_tri_base(model_tri_base), .model_tri_count(model_tri_count),
    .vert_addr(vert_addr), .vert_rd_en(vert_rd_en), .vert_data(vert_data),
    .camera_transform_valid(camera_transform_valid), .transform(transform),
    .triangle(triangle), .out_valid(out_valid), .out_ready(out_ready),
    .down_busy(down_busy), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memories: model table and a vertex store whose contents are a function of address.
  transform_t  tbl_xf   [256];
  logic [15:0] tbl_base [256];
  logic [15:0] tbl_cnt  [256];
  logic [15:0] seed = 16'h1234;

  function automatic vertex_t vtx_of(input logic [15:0] a, input logic [15:0] s);
    vertex_t v;
    v.x = a ^ s;
    v.y = a + s;
    v.z = ~a;
    return v;
  endfunction

  always @(posedge clk) begin
    if (model_rd_en) begin
      model_transform <= tbl_xf[model_addr];
      model_tri_base  <= tbl_base[model_addr];
      model_tri_count <= tbl_cnt[model_addr];
    end
    if (vert_rd_en) vert_data <= vtx_of(vert_addr, seed);
  end

  // Scoreboard state
  exp_t        exp_q   [$];
  logic [15:0] addr_q  [$];
  logic [7:0]  maddr_q [$];
  transform_t  cam_q   [$];
  int          pending_done = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cam_cyc = -1;
  int          done_cyc = -1;
  int          done_cnt = 0;
  int          ov_cnt = 0;
  int          xfer_cyc [$];
  bit          cam_seen = 1'b0;

  task automatic chk(input bit ok, input string name, input logic [207:0] act,
                     input logic [207:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flush_sb();
    exp_q.delete();
    addr_q.delete();
    maddr_q.delete();
    cam_q.delete();
    pending_done = 0;
    cam_seen = 1'b0;
  endtask

  // Frame-level reference: camera load, then every triangle of every model in order.
  task automatic ref_frame(input int n, input transform_t cam);
    cam_q.push_back(cam);
    for (int m = 0; m < n; m++) begin
      maddr_q.push_back(8'(m));
      for (int t = 0; t < int'(tbl_cnt[m]); t++) begin
        exp_t e;
        logic [15:0] a [3];
        for (int k = 0; k < 3; k++) begin
          a[k] = 16'(int'(tbl_base[m]) + 3 * t + k);
          addr_q.push_back(a[k]);
        end
        e.tri_v.v0 = vtx_of(a[0], seed);
        e.tri_v.v1 = vtx_of(a[1], seed);
        e.tri_v.v2 = vtx_of(a[2], seed);
        e.xf = tbl_xf[m];
        exp_q.push_back(e);
      end
    end
    pending_done++;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (camera_transform_valid) begin
        cam_cyc = cyc;
        cam_seen = 1'b1;
        chk(cam_q.size() != 0, "cam_expected", 208'(cam_q.size()), 208'(1));
        if (cam_q.size() != 0) begin
          transform_t c;
          c = cam_q.pop_front();
          chk(transform == c, "cam_transform", 208'(transform), 208'(c));
        end
        chk(!out_valid, "cam_ov_exclusive", 208'(out_valid), 208'(0));
      end
      if (out_valid) begin
        ov_cnt++;
        chk(cam_seen, "ov_after_cam", 208'(cam_seen), 208'(1));
        if (out_ready) begin
          xfer_cyc.push_back(cyc);
          chk(exp_q.size() != 0, "tri_expected", 208'(exp_q.size()), 208'(1));
          if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({triangle, transform} == e, "triangle", {triangle, transform}, e);
          end
        end
      end
      if (vert_rd_en) begin
        chk(addr_q.size() != 0, "vaddr_expected", 208'(addr_q.size()), 208'(1));
        if (addr_q.size() != 0) begin
          logic [15:0] a;
          a = addr_q.pop_front();
          chk(vert_addr == a, "vert_addr", 208'(vert_addr), 208'(a));
        end
      end
      if (model_rd_en) begin
        chk(maddr_q.size() != 0, "maddr_expected", 208'(maddr_q.size()), 208'(1));
        if (maddr_q.size() != 0) begin
          logic [7:0] ma;
          ma = maddr_q.pop_front();
          chk(model_addr == ma, "model_addr", 208'(model_addr), 208'(ma));
        end
      end
      if (done) begin
        done_cyc = cyc;
        done_cnt++;
        cam_seen = 1'b0;
        chk(pending_done > 0, "done_expected", 208'(pending_done), 208'(1));
        if (pending_done > 0) pending_done--;
      end
    end
  end

  // Handshake drivers
  int rdy_mode = 0;
  bit busy_rand = 1'b0;
  bit busy_force = 1'b0;
  initial begin
    out_ready = 1'b0;
    down_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom % 4) != 0;
        default: out_ready = 1'b0;
      endcase
      down_busy = busy_rand ? (($urandom % 3) == 0) : busy_force;
    end
  end

  task automatic do_start(input int n);
    transform_t cam;
    cam = transform_t'({$urandom(), $urandom()});
    @(posedge clk);
    #1;
    ref_frame(n, cam);
    start = 1'b1;
    num_models = 8'(n);
    camera_transform = cam;
    @(posedge clk);
    #1;
    start = 1'b0;
    camera_transform = '0;
  endtask

  task automatic wait_done(input int budget);
    int c0;
    int i;
    c0 = done_cnt;
    i = 0;
    while (done_cnt == c0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    chk(done_cnt != c0, "frame_timeout", 208'(i), 208'(budget));
    chk(exp_q.size() == 0 && addr_q.size() == 0 && maddr_q.size() == 0 && cam_q.size() == 0,
        "sb_drained", 208'(exp_q.size() + addr_q.size()), 208'(0));
  endtask

  task automatic set_model(input int m, input logic [15:0] base, input logic [15:0] cnt);
    tbl_xf[m]   = transform_t'({$urandom(), $urandom()});
    tbl_base[m] = base;
    tbl_cnt[m]  = cnt;
  endtask

  initial begin
    int x;
    int i;
    int d0;
    int ov0;
    rst = 1'b1;
    start = 1'b0;
    num_models = '0;
    camera_transform = '0;
    repeat (3) @(negedge clk);
    chk(busy == 0, "rst_busy", 208'(busy), 208'(0));
    chk(out_valid == 0 && camera_transform_valid == 0 && done == 0, "rst_strobes",
        208'({out_valid, camera_transform_valid, done}), 208'(0));
    chk(vert_rd_en == 0 && model_rd_en == 0 && vert_addr == 0 && model_addr == 0, "rst_reads",
        208'({vert_rd_en, model_rd_en, vert_addr, model_addr}), 208'(0));
    chk({triangle, transform} == '0, "rst_data", {triangle, transform}, 208'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);

    // Empty frame: camera pulse, done two cycles later, no triangles.
    ov0 = ov_cnt;
    cam_cyc = -1;
    do_start(0);
    wait_done(100);
    chk(done_cyc - cam_cyc == 2, "empty_done_latency", 208'(done_cyc - cam_cyc), 208'(2));
    chk(ov_cnt == ov0, "empty_no_ov", 208'(ov_cnt), 208'(ov0));

    // One model, two triangles from address 0; full-rate handshake.
    set_model(0, 16'h0000, 16'd2);
    xfer_cyc.delete();
    d0 = done_cnt;
    do_start(1);
    wait_done(200);
    repeat (4) @(posedge clk);
    chk(done_cnt == d0 + 1, "done_once", 208'(done_cnt - d0), 208'(1));
    chk(xfer_cyc.size() == 2, "two_transfers", 208'(xfer_cyc.size()), 208'(2));
    if (xfer_cyc.size() == 2)
      chk(xfer_cyc[1] - xfer_cyc[0] == 5, "throughput", 208'(xfer_cyc[1] - xfer_cyc[0]), 208'(5));

    // Stall for 10 cycles in EMIT.
    seed = 16'h9e37;
    set_model(0, 16'h0400, 16'd1);
    rdy_mode = 2;
    do_start(1);
    i = 0;
    while (!out_valid && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk(out_valid == 1, "stall_reach_emit", 208'(i), 208'(200));
    repeat (10) begin
      @(negedge clk);
      chk(out_valid == 1, "stall_valid", 208'(out_valid), 208'(1));
      if (exp_q.size() != 0)
        chk({triangle, transform} == exp_q[0], "stall_stable", {triangle, transform}, exp_q[0]);
    end
    rdy_mode = 0;
    wait_done(200);

    // Downstream busy delays the camera load.
    set_model(0, 16'h0010, 16'd1);
    busy_force = 1'b1;
    repeat (2) @(posedge clk);
    cam_cyc = -1;
    do_start(1);
    repeat (6) @(posedge clk);
    busy_force = 1'b0;
    #1 x = cyc;
    chk(cam_cyc == -1, "cam_held_while_busy", 208'(cam_cyc), 208'(-1));
    wait_done(200);
    chk(cam_cyc == x + 1, "cam_after_busy", 208'(cam_cyc), 208'(x + 1));

    // Vertex address wraps at the top of memory.
    set_model(0, 16'hFFFE, 16'd1);
    do_start(1);
    wait_done(200);

    // Reset in the middle of a vertex fetch.
    set_model(0, 16'h0100, 16'd3);
    set_model(1, 16'h0200, 16'd2);
    do_start(2);
    i = 0;
    do begin
      @(posedge clk);
      #1;
      i++;
    end while (!vert_rd_en && i < 200);
    chk(vert_rd_en == 1, "reach_fetch", 208'(i), 208'(200));
    #2 rst = 1'b1;
    #1;
    chk(vert_rd_en == 0 && busy == 0 && out_valid == 0 && model_rd_en == 0, "midrst_ctrl",
        208'({vert_rd_en, busy, out_valid, model_rd_en}), 208'(0));
    chk(vert_addr == 0 && camera_transform_valid == 0 && done == 0, "midrst_addr",
        208'({vert_addr, camera_transform_valid, done}), 208'(0));
    chk({triangle, transform} == '0, "midrst_data", {triangle, transform}, 208'(0));
    flush_sb();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    set_model(0, 16'h0300, 16'd2);
    do_start(1);
    wait_done(200);

    // Randomised frames with random backpressure and downstream occupancy.
    rdy_mode = 1;
    busy_rand = 1'b1;
    repeat (10) begin
      int n;
      seed = 16'($urandom);
      n = $urandom_range(0, 4);
      for (int m = 0; m < n; m++)
        set_model(m, ($urandom % 3 == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF)) : 16'($urandom),
                  16'($urandom_range(0, 4)));
      do_start(n);
      wait_done(2000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
